// File: rtl/ad9833_rx.sv
// AD9833-style serial word receiver: synchronizes fsync/sclk/sdata, assembles
// 16-bit MSB-first words and decodes them into control, frequency and phase registers.
module ad9833_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fsync,
    input  logic        sclk,
    input  logic        sdata,
    output logic [15:0] word,
    output logic        word_valid,
    output logic [13:0] ctrl,
    output logic [27:0] freq0,
    output logic [27:0] freq1,
    output logic [11:0] phase0,
    output logic [11:0] phase1,
    output logic        frame_err
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] fsync_sync, sclk_sync, sdata_sync;
    logic                   fsync_s, sclk_s, sdata_s, sclk_prev;
    logic                   sclk_fall, take_bit, word_done, abort, leave;
    logic [15:0]            shreg, shreg_next;
    logic [3:0]             bit_cnt;
    logic                   pend, pend_sel;

    logic [13:0] ctrl_d, payload;
    logic [27:0] freq0_d, freq1_d, freq_cur, freq_new;
    logic [11:0] phase0_d, phase1_d;
    logic        pend_d, pend_sel_d, write_hi;

    // NOTE: synchronizers reset to the bus idle levels so reset release never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsync_sync <= '1;
            sclk_sync  <= '1;
            sdata_sync <= '0;
            sclk_prev  <= 1'b1;
        end else begin
            fsync_sync <= {fsync_sync[SYNC_STAGES-2:0], fsync};
            sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], sdata};
            sclk_prev  <= sclk_s;
        end
    end

    assign fsync_s    = fsync_sync[SYNC_STAGES-1];
    assign sclk_s     = sclk_sync[SYNC_STAGES-1];
    assign sdata_s    = sdata_sync[SYNC_STAGES-1];
    assign sclk_fall  = sclk_prev & ~sclk_s;
    assign take_bit   = sclk_fall & ~fsync_s;
    assign word_done  = take_bit && (bit_cnt == 4'd15);
    assign shreg_next = {shreg[14:0], sdata_s};
    assign leave      = (state == SHIFT) && fsync_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // A rising fsync beats a simultaneous sclk edge: take_bit is already gated off.
    always_comb begin
        state_next = state;
        abort      = 1'b0;
        case (state)
            IDLE:    if (!fsync_s) state_next = SHIFT;
            SHIFT:   if (fsync_s) begin
                         state_next = IDLE;
                         abort      = (bit_cnt != 4'd0);
                     end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ctrl_d     = ctrl;
        freq0_d    = freq0;
        freq1_d    = freq1;
        phase0_d   = phase0;
        phase1_d   = phase1;
        pend_d     = pend;
        pend_sel_d = pend_sel;
        payload    = shreg_next[13:0];
        freq_cur   = shreg_next[15] ? freq1 : freq0;
        freq_new   = freq_cur;
        write_hi   = 1'b0;
        case (shreg_next[15:14])
            2'b00: begin
                ctrl_d = payload;
                pend_d = 1'b0;
            end
            2'b01, 2'b10: begin
                if (ctrl[13]) begin
                    write_hi   = pend && (pend_sel == shreg_next[15]);
                    pend_d     = !write_hi;
                    pend_sel_d = shreg_next[15];
                end else begin
                    write_hi = ctrl[12];
                    pend_d   = 1'b0;
                end
                freq_new = write_hi ? {payload, freq_cur[13:0]} : {freq_cur[27:14], payload};
                if (shreg_next[15]) freq1_d = freq_new;
                else                freq0_d = freq_new;
            end
            default: begin
                if (shreg_next[13]) phase1_d = shreg_next[11:0];
                else                phase0_d = shreg_next[11:0];
            end
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            pend       <= 1'b0;
            pend_sel   <= 1'b0;
            word       <= '0;
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            ctrl       <= '0;
            freq0      <= '0;
            freq1      <= '0;
            phase0     <= '0;
            phase1     <= '0;
        end else begin
            word_valid <= 1'b0;
            frame_err  <= abort;
            if (leave) begin
                shreg   <= '0;
                bit_cnt <= '0;
            end else if (take_bit) begin
                shreg   <= shreg_next;
                bit_cnt <= bit_cnt + 4'd1;
                if (word_done) begin
                    word       <= shreg_next;
                    word_valid <= 1'b1;
                    ctrl       <= ctrl_d;
                    freq0      <= freq0_d;
                    freq1      <= freq1_d;
                    phase0     <= phase0_d;
                    phase1     <= phase1_d;
                    pend       <= pend_d;
                    pend_sel   <= pend_sel_d;
                end
            end
        end
    end

endmodule

// File: doc/ad9833_rx.md
AD9833_RX -- requirements
Module: ad9833_rx

Interface
REQ-001 Parameter: SYNC_STAGES, default 2, number of flip-flops in each input synchronizer (minimum 2).
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 fsync  input  1  frame sync from the serial master; active-low.
REQ-005 sclk  input  1  serial clock from the master; idles high.
REQ-006 sdata  input  1  serial data, MSB first, valid at the sclk falling edge.
REQ-007 word  output  16  last complete received word.
REQ-008 word_valid  output  1  one-cycle pulse; word was updated this cycle.
REQ-009 ctrl  output  14  control register, D13..D0 of the last control word.
REQ-010 freq0 / freq1  output  28 each  frequency registers.
REQ-011 phase0 / phase1  output  12 each  phase registers.
REQ-012 frame_err  output  1  one-cycle pulse; fsync deasserted mid-word.

Function
REQ-013 fsync, sclk and sdata each pass through a SYNC_STAGES-deep synchronizer before any use.
REQ-014 Falling edge is synchronized sclk high in the previous cycle and low in the current cycle; it is processed only while synchronized fsync is low.
REQ-015 On each processed falling edge: shift synchronized sdata into the LSB of a 16-bit shift register and increment a 4-bit bit counter.
REQ-016 When the counter wraps 15->0, assert word_valid in the next cycle and present the assembled word on word.
REQ-017 Decoded registers update on the same clock edge that asserts word_valid.
REQ-018 Multiple words per fsync-low frame are allowed; counting continues across word boundaries.
REQ-019 States: IDLE (fsync high), SHIFT (fsync low). IDLE->SHIFT on synchronized fsync falling. SHIFT->IDLE on synchronized fsync rising.
REQ-020 On SHIFT->IDLE with counter != 0: pulse frame_err for one cycle, discard the partial word, clear the counter, leave decoded registers unchanged.
REQ-021 On SHIFT->IDLE with counter == 0: return to IDLE silently.
REQ-022 If fsync rises in the same cycle as the 16th falling edge, the fsync rise wins: the edge is not processed and REQ-020 applies (counter == 15).
REQ-023 Decode word[15:14] = 00: write ctrl <= word[13:0] and clear the B28 pending flag.
REQ-024 Decode word[15:14] = 01 or 10: write FREQ0 or FREQ1 respectively; payload is word[13:0].
REQ-025 If ctrl[13] (B28) = 1, a frequency write with no pending flag, or with the flag pending for the other register, writes payload to bits [13:0]; it then sets pending with that target.
REQ-026 If B28 = 1, a frequency write with pending for the same register writes payload to bits [27:14] and clears pending.
REQ-027 If B28 = 0, ctrl[12] (HLB) = 1 writes bits [27:14], HLB = 0 writes bits [13:0]; pending stays clear.
REQ-028 Decode word[15:13] = 110: phase0 <= word[11:0]. Decode word[15:13] = 111: phase1 <= word[11:0]. word[12] is ignored.
REQ-029 Untouched register bits always retain their values.

Reset
REQ-030 While rst_n is low: all synchronizer flops at idle level (fsync=1, sclk=1, sdata=0); state IDLE; counter, shift register and pending flag cleared.
REQ-031 While rst_n is low, all outputs are zero: word, word_valid, ctrl, freq0, freq1, phase0, phase1, frame_err.
REQ-032 Reset asserted mid-word discards the partial word without a frame_err pulse; after release, reception starts only on a new fsync falling edge.

Verification
REQ-033 Stimulus: control word 0x2000, then 0x4ABC and 0x4123 in one frame. Required: ctrl=0x2000, then freq0=0x048C ABC (28'h048CABC), three word_valid pulses.
REQ-034 Stimulus: 0x1000 (HLB=1), then 0x8005. Required: freq1[27:14]=14'h0005, freq1[13:0] unchanged.
REQ-035 Stimulus: 0xC123 then 0xE456. Required: phase0=12'h123, phase1=12'h456, frequency registers unchanged.
REQ-036 Stimulus: fsync raised after 9 bits. Required: exactly one frame_err pulse, no word_valid, registers unchanged; the next full word decodes correctly.
REQ-037 Stimulus: rst_n pulsed low mid-word. Required: all outputs 0 immediately; no frame_err; a following 0x2100 gives ctrl=0x2100.
REQ-038 Stimulus: sclk toggling while fsync is high. Required: counter stays 0, no word_valid.
